alu_share_sched: RTL
====================

Name: alu_share_sched

Overview:
Time-multiplexes the single 16-bit combinational ALU between two requesters: port 0 is the pipeline EX stage, port 1 is the auxiliary/microcode unit. The block arbitrates round-robin and latches the operands and funct into registers that drive the ALU. It holds those operands for a funct-dependent number of cycles, then captures result, R0 and branch and returns them to the granted requester. It sits between the requesters and the ALU instance and owns the ALU's funct/operand inputs.

Parameters:
DATA_W, 16, operand/result width (the ALU is 16-bit; only 16 is supported)
MULDIV_LAT, 4, EXEC cycles held for funct 4'b0001 (mul) and 4'b0010 (div); legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  port 0 request
req0_ready  out  1  port 0 accept (combinational)
req0_funct  in  4  port 0 ALU funct
req0_a  in  16  port 0 operand A
req0_b  in  16  port 0 operand B
rsp0_valid  out  1  port 0 response pulse
rsp0_result  out  16  port 0 result
rsp0_r0  out  16  port 0 high product / remainder
rsp0_branch  out  1  port 0 branch decision
req1_* / rsp1_*  same as port 0, for port 1
alu_funct  out  4  to ALU funct
alu_a  out  16  to ALU Rout1
alu_b  out  16  to ALU Rout2
alu_result  in  16  from ALU result
alu_r0  in  16  from ALU R0
alu_branch  in  1  from ALU branch
busy  out  1  high whenever state != IDLE
div_err  out  1  one-cycle pulse coincident with a divide-by-zero response

Behaviour:
- Reset values: state=IDLE, rr_ptr=0 (port 0 favoured), alu_funct=4'b0000, alu_a=alu_b=0, all rsp_* outputs=0, busy=0, div_err=0. Reset mid-operation drops the in-flight op; no response is ever issued for it.
- FSM states are IDLE, EXEC and RESP.
- IDLE: reqN_ready = (state==IDLE) && grantN.
  - If only one valid is high, grant that port.
  - If both are high, grant the port selected by rr_ptr.
  - Handshake completes on valid&&ready at the clock edge. On that edge, latch funct/a/b into alu_* and record the owner. Set rr_ptr to the other port, set cnt, then go to EXEC.
  - No valid: stay in IDLE and hold alu_* unchanged.
- cnt load value: MULDIV_LAT for funct 0001/0010, otherwise 1.
- Divide-by-zero: funct 0010 with b==0 goes straight to RESP without entering EXEC. It returns result=16'hFFFF, r0=a, branch=0, and pulses div_err with rsp_valid.
- EXEC: decrement cnt each cycle. When cnt==1, capture alu_result, alu_r0 and alu_branch into the response registers and go to RESP.
- Branch masking: the captured branch is forced to 0 unless funct is 0011, 0100 or 0101.
- Undefined functs (0000, 0110, 0111) take the 1-cycle path. They return result=0, r0=0, branch=0 regardless of ALU outputs.
- RESP: rsp_valid of the owner is high for exactly one cycle; the other port's rsp_valid stays 0. rsp_result/r0/branch hold their values until the next capture. The FSM returns to IDLE.
- Latency: with accept edge at T, single-cycle ops have rsp_valid high in cycle T+2 (EXEC in T+1). Mul/div ops have rsp_valid high in cycle T+1+MULDIV_LAT. Divide-by-zero has rsp_valid high in cycle T+1.
- Throughput: at most one op in flight. A new grant is possible in the cycle after RESP.
- A requester must hold valid, funct and operands stable until ready. A dropped valid before ready is legal and produces no grant.
- Simultaneous requests alternate strictly. A lone requester may be granted back-to-back regardless of rr_ptr.

Optional Feature:
Macro: ALU_SHARE_PERF_EN.
- Defined: adds three 16-bit saturating counters, each cleared by rst and each holding at 16'hFFFF:
  - perf_grant0 out 16: counts port 0 accepts.
  - perf_grant1 out 16: counts port 1 accepts.
  - perf_stall out 16: counts cycles where any reqN_valid && !reqN_ready.
- Not defined: all three ports still exist, tied to 16'h0000, and no counter logic is generated.

Test Plan:
- Port 0 add: funct 1111, a=3, b=5, accepted at T -> rsp0_valid in T+2 with result 8, r0 0, branch 0; rsp1_valid stays 0.
- Port 1 mul, MULDIV_LAT=4: a=16'h0100, b=16'h0100 -> rsp1_valid in T+5 with result 16'h0000, r0 16'h0001; busy high for T+1..T+5.
- Both valid every cycle with port 0 BEQ (a=b=7) and port 1 SUB (a=9, b=4) after reset -> grants go 0,1,0,1. Port 0 gets branch=1; port 1 gets result 5, branch 0.
- Div-by-zero on port 0: funct 0010, a=20, b=0 -> rsp0_valid and div_err in T+1, result 16'hFFFF, r0 20, no EXEC cycle.
- rst asserted during EXEC of a div -> next cycle state IDLE, busy 0, no rsp_valid. A subsequent port 1 request is granted normally, with port 0 favoured on a tie.
- ALU_SHARE_PERF_EN defined: three accepted ops plus two stalled cycles -> perf_grant0+perf_grant1=3, perf_stall=2. With the macro undefined -> all perf ports read 0.

Source files
------------

// File: rtl/alu_share_sched.sv
// Round-robin time-multiplexer for one 16-bit ALU (port 0 = EX, port 1 = aux).
// Define ALU_SHARE_PERF_EN for saturating grant/stall counters on perf_*.
module alu_share_sched #(
  parameter int DATA_W     = 16,
  parameter int MULDIV_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_funct,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_result,
  output logic [DATA_W-1:0] rsp0_r0,
  output logic              rsp0_branch,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_funct,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_result,
  output logic [DATA_W-1:0] rsp1_r0,
  output logic              rsp1_branch,
  output logic [3:0]        alu_funct,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] alu_r0,
  input  logic              alu_branch,
  output logic              busy,
  output logic              div_err,
  output logic [15:0]       perf_grant0,
  output logic [15:0]       perf_grant1,
  output logic [15:0]       perf_stall
);

  localparam logic [3:0] F_MUL = 4'b0001;
  localparam logic [3:0] F_DIV = 4'b0010;
  localparam logic [3:0] LAT   = 4'(MULDIV_LAT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_n;

  logic              rr_ptr;
  logic              owner;
  logic              dz;
  logic [3:0]        cnt;
  logic              g0, g1, acc, sel;
  logic [3:0]        sel_f;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic              sel_dz, sel_md;
  logic              f_undef, f_br;
  logic              cap_en, cap_own, cap_br;
  logic [DATA_W-1:0] cap_res, cap_r0;
  logic [DATA_W-1:0] res0_q, r00_q, res1_q, r01_q;
  logic              br0_q, br1_q;

  assign g0 = req0_valid && (!req1_valid || !rr_ptr);
  assign g1 = req1_valid && (!req0_valid || rr_ptr);
  assign req0_ready = (state == IDLE) && g0;
  assign req1_ready = (state == IDLE) && g1;
  assign acc = req0_ready || req1_ready;
  assign sel = req1_ready;

  assign sel_f  = sel ? req1_funct : req0_funct;
  assign sel_a  = sel ? req1_a : req0_a;
  assign sel_b  = sel ? req1_b : req0_b;
  assign sel_dz = (sel_f == F_DIV) && (sel_b == '0);
  assign sel_md = (sel_f == F_MUL) || (sel_f == F_DIV);

  assign f_undef = alu_funct inside {4'b0000, 4'b0110, 4'b0111};
  assign f_br    = alu_funct inside {4'b0011, 4'b0100, 4'b0101};

  always_comb begin
    state_n = state;
    cap_en  = 1'b0;
    cap_own = owner;
    cap_res = alu_result;
    cap_r0  = alu_r0;
    cap_br  = alu_branch;
    unique case (state)
      IDLE: begin
        if (acc) begin
          cap_own = sel;
          // div-by-zero never reaches the ALU hold phase
          if (sel_dz) begin
            state_n = RESP;
            cap_en  = 1'b1;
            cap_res = '1;
            cap_r0  = sel_a;
            cap_br  = 1'b0;
          end else begin
            state_n = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt == 4'd1) begin
          state_n = RESP;
          cap_en  = 1'b1;
          unique case (1'b1)
            f_undef: begin
              cap_res = '0;
              cap_r0  = '0;
              cap_br  = 1'b0;
            end
            f_br:    cap_br = alu_branch;
            default: cap_br = 1'b0;
          endcase
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      owner     <= 1'b0;
      dz        <= 1'b0;
      cnt       <= 4'd0;
      alu_funct <= 4'b0000;
      alu_a     <= '0;
      alu_b     <= '0;
      res0_q    <= '0;
      r00_q     <= '0;
      br0_q     <= 1'b0;
      res1_q    <= '0;
      r01_q     <= '0;
      br1_q     <= 1'b0;
    end else begin
      state <= state_n;
      if (acc) begin
        alu_funct <= sel_f;
        alu_a     <= sel_a;
        alu_b     <= sel_b;
        owner     <= sel;
        rr_ptr    <= !sel;
        dz        <= sel_dz;
        cnt       <= sel_md ? LAT : 4'd1;
      end else if (state == EXEC) begin
        cnt <= cnt - 4'd1;
      end
      if (cap_en && !cap_own) begin
        res0_q <= cap_res;
        r00_q  <= cap_r0;
        br0_q  <= cap_br;
      end
      if (cap_en && cap_own) begin
        res1_q <= cap_res;
        r01_q  <= cap_r0;
        br1_q  <= cap_br;
      end
    end
  end

  assign rsp0_valid  = (state == RESP) && !owner;
  assign rsp1_valid  = (state == RESP) && owner;
  assign rsp0_result = res0_q;
  assign rsp0_r0     = r00_q;
  assign rsp0_branch = br0_q;
  assign rsp1_result = res1_q;
  assign rsp1_r0     = r01_q;
  assign rsp1_branch = br1_q;
  assign busy        = (state != IDLE);
  assign div_err     = (state == RESP) && dz;

`ifdef ALU_SHARE_PERF_EN
  logic stall;

  assign stall = (req0_valid && !req0_ready) ||
                 (req1_valid && !req1_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant0 <= 16'h0000;
      perf_grant1 <= 16'h0000;
      perf_stall  <= 16'h0000;
    end else begin
      if (req0_ready && (perf_grant0 != 16'hFFFF))
        perf_grant0 <= perf_grant0 + 16'd1;
      if (req1_ready && (perf_grant1 != 16'hFFFF))
        perf_grant1 <= perf_grant1 + 16'd1;
      if (stall && (perf_stall != 16'hFFFF))
        perf_stall <= perf_stall + 16'd1;
    end
  end
`else
  assign perf_grant0 = 16'h0000;
  assign perf_grant1 = 16'h0000;
  assign perf_stall  = 16'h0000;
`endif

endmodule
